// File: rtl/canon_pkg.sv
// rtl/canon_pkg.sv - shared timebase types, defaults and ground-bass table
package canon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    localparam int DEFAULT_CROTCHET_CYCLES      = 10_972_500;
    localparam int DEFAULT_CROTCHETS_PER_PHRASE = 32;

    // Semitone offsets from D: D A B F# G D G A
    localparam logic [3:0] GROUND_BASS [8] = '{
        4'd0, 4'd7, 4'd9, 4'd4, 4'd5, 4'd0, 4'd5, 4'd7
    };

    function automatic logic [3:0] ground_note(input logic [2:0] idx);
        return GROUND_BASS[idx];
    endfunction

endpackage

// File: rtl/beat_divider.sv
// rtl/beat_divider.sv - crotchet cycle counter with terminal and half-point strobes
module beat_divider
    import canon_pkg::*;
#(
    parameter int CROTCHET_CYCLES = DEFAULT_CROTCHET_CYCLES,
    parameter int CYC_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_terminal,
    output logic o_half
);

    localparam logic [CYC_W-1:0] TERM     = CYC_W'(CROTCHET_CYCLES - 1);
    // Strobe one count early so the registered quaver lines up with cyc==CROTCHET_CYCLES/2
    localparam logic [CYC_W-1:0] HALF_PRE = CYC_W'(CROTCHET_CYCLES / 2 - 1);

    logic [CYC_W-1:0] r_cyc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc <= '0;
        end else if (i_clear) begin
            r_cyc <= '0;
        end else if (i_count) begin
            r_cyc <= o_terminal ? '0 : r_cyc + CYC_W'(1);
        end
    end

    assign o_terminal = (r_cyc == TERM);
    assign o_half     = (r_cyc == HALF_PRE);

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - musical timebase: crotchet/quaver/phrase strobes, beat/bar and ground bass
module beat_sequencer
    import canon_pkg::*;
#(
    parameter int CROTCHET_CYCLES      = DEFAULT_CROTCHET_CYCLES,
    parameter int CROTCHETS_PER_PHRASE = DEFAULT_CROTCHETS_PER_PHRASE,
    parameter int CYC_W                = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart,
    output logic       crotchet,
    output logic       quaver,
    output logic       phrase,
    output logic [5:0] beat,
    output logic [3:0] bar,
    output logic [3:0] bass_note
);

    localparam logic [5:0] BEAT_LAST = 6'(CROTCHETS_PER_PHRASE - 1);

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic       w_clear;
    logic       w_count;
    logic       w_start;
    logic       w_terminal;
    logic       w_half;
    logic       w_wrap;
    logic [5:0] w_beat_next;

    logic       r_crotchet;
    logic       r_quaver;
    logic       r_phrase;
    logic [5:0] r_beat;
    logic [3:0] r_bar;
    logic [3:0] r_bass;

    beat_divider #(
        .CROTCHET_CYCLES (CROTCHET_CYCLES),
        .CYC_W           (CYC_W)
    ) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_count    (w_count),
        .o_terminal (w_terminal),
        .o_half     (w_half)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A paused sequencer counts on the resume edge itself, so a frozen terminal fires at once.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_count      = 1'b0;
        w_start      = 1'b0;
        if (restart) begin
            w_clear = 1'b1;
            if (enable) begin
                w_state_next = RUN;
                w_start      = 1'b1;
            end else begin
                w_state_next = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_clear = 1'b1;
                    if (enable) begin
                        w_state_next = RUN;
                        w_start      = 1'b1;
                    end
                end
                RUN: begin
                    if (enable) begin
                        w_count = 1'b1;
                    end else begin
                        w_state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (enable) begin
                        w_state_next = RUN;
                        w_count      = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    assign w_wrap = w_count && w_terminal;

    always_comb begin
        w_beat_next = r_beat;
        if (w_clear) begin
            w_beat_next = '0;
        end else if (w_wrap) begin
            w_beat_next = (r_beat + 6'd1) & BEAT_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crotchet <= 1'b0;
            r_quaver   <= 1'b0;
            r_phrase   <= 1'b0;
            r_beat     <= '0;
            r_bar      <= '0;
            r_bass     <= '0;
        end else begin
            r_crotchet <= w_start || w_wrap;
            r_quaver   <= w_start || w_wrap || (w_count && w_half);
            r_phrase   <= w_wrap && (r_beat == BEAT_LAST);
            r_beat     <= w_beat_next;
            r_bar      <= w_beat_next[5:2];
            r_bass     <= ground_note(w_beat_next[2:0]);
        end
    end

    assign crotchet  = r_crotchet;
    assign quaver    = r_quaver;
    assign phrase    = r_phrase;
    assign beat      = r_beat;
    assign bar       = r_bar;
    assign bass_note = r_bass;

endmodule
